// File: rtl/conv_result_writer.sv
// conv_result_writer: gathers skewed per-lane accumulator results, applies
// optional ReLU, packs one result per lane into a word and writes it to the
// ofmap buffer, one write per complete lane set.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start_i           one-cycle layer start (accepted only in IDLE)
//   ofmap_size_i      ofmap side length, latched on an accepted start
//   relu_en_i         ReLU enable, latched on an accepted start
//   conv_valid_i      per-lane result valid
//   conv_last_i       per-lane last-result marker
//   conv_result_i     per-lane signed results, lane c at [8c+7:8c]
//   wr_en_o           buffer write strobe
//   wr_addr_o         buffer word address
//   wr_data_o         packed word, lane c at [8c+7:8c]
//   busy_o            high while collecting
//   done_o            one-cycle completion pulse
//   overrun_o         sticky: a lane result was dropped
//   last_err_o        sticky: last markers disagree with the word count
module conv_result_writer #(
   parameter int N_COL  = 16,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_i,
   input  logic [4:0]              ofmap_size_i,
   input  logic                    relu_en_i,
   input  logic [N_COL-1:0]        conv_valid_i,
   input  logic [N_COL-1:0]        conv_last_i,
   input  logic [N_COL*DATA_W-1:0] conv_result_i,
   output logic                    wr_en_o,
   output logic [ADDR_W-1:0]       wr_addr_o,
   output logic [N_COL*DATA_W-1:0] wr_data_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    overrun_o,
   output logic                    last_err_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_DONE
   } state_t;

   state_t                    state_q, state_d;
   logic [4:0]                size_q, size_d;
   logic                      relu_q, relu_d;
   logic [ADDR_W-1:0]         cnt_q, cnt_d;
   logic [N_COL-1:0]          full_q, full_d;
   logic [N_COL-1:0]          last_q, last_d;
   logic [N_COL*DATA_W-1:0]   data_q, data_d;
   logic                      overrun_q, overrun_d;
   logic                      last_err_q, last_err_d;
   logic [ADDR_W-1:0]         addr_hold_q, addr_hold_d;
   logic [N_COL*DATA_W-1:0]   data_hold_q, data_hold_d;

   logic                      wr_en;
   logic [9:0]                size_sq;
   logic [ADDR_W-1:0]         final_idx;
   logic                      is_final;
   logic                      last_and;
   logic                      last_or;
   logic [DATA_W-1:0]         res;

   assign size_sq   = 10'(size_q) * 10'(size_q);
   assign final_idx = ADDR_W'(size_sq) - ADDR_W'(1);
   assign is_final  = (cnt_q == final_idx);
   assign wr_en     = (state_q == S_COLLECT) && (&full_q);
   assign last_and  = &last_q;
   assign last_or   = |last_q;

   always_comb begin
      state_d     = state_q;
      size_d      = size_q;
      relu_d      = relu_q;
      cnt_d       = cnt_q;
      full_d      = full_q;
      last_d      = last_q;
      data_d      = data_q;
      overrun_d   = overrun_q;
      last_err_d  = last_err_q;
      addr_hold_d = addr_hold_q;
      data_hold_d = data_hold_q;
      res         = '0;
      case (state_q)
         S_IDLE: begin
            full_d = '0;
            if (start_i) begin
               size_d     = ofmap_size_i;
               relu_d     = relu_en_i;
               cnt_d      = '0;
               overrun_d  = 1'b0;
               last_err_d = 1'b0;
               state_d    = (ofmap_size_i == 5'd0) ? S_DONE : S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (wr_en) begin
               full_d      = '0;
               cnt_d       = cnt_q + ADDR_W'(1);
               addr_hold_d = cnt_q;
               data_hold_d = data_q;
               if ((last_or && (!last_and || !is_final)) ||
                   (is_final && !last_and))
                  last_err_d = 1'b1;
               if (is_final)
                  state_d = S_DONE;
            end
            // A slot being emptied this cycle takes the new value
            // directly, except on the layer's final write.
            for (int c = 0; c < N_COL; c++) begin
               if (conv_valid_i[c]) begin
                  if (wr_en ? !is_final : !full_q[c]) begin
                     res = conv_result_i[c*DATA_W +: DATA_W];
                     if (relu_q && res[DATA_W-1])
                        res = '0;
                     data_d[c*DATA_W +: DATA_W] = res;
                     last_d[c] = conv_last_i[c];
                     full_d[c] = 1'b1;
                  end else if (!wr_en) begin
                     overrun_d = 1'b1;
                  end
               end
            end
         end
         S_DONE: begin
            full_d  = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         size_q      <= '0;
         relu_q      <= 1'b0;
         cnt_q       <= '0;
         full_q      <= '0;
         last_q      <= '0;
         data_q      <= '0;
         overrun_q   <= 1'b0;
         last_err_q  <= 1'b0;
         addr_hold_q <= '0;
         data_hold_q <= '0;
      end else begin
         state_q     <= state_d;
         size_q      <= size_d;
         relu_q      <= relu_d;
         cnt_q       <= cnt_d;
         full_q      <= full_d;
         last_q      <= last_d;
         data_q      <= data_d;
         overrun_q   <= overrun_d;
         last_err_q  <= last_err_d;
         addr_hold_q <= addr_hold_d;
         data_hold_q <= data_hold_d;
      end
   end

   assign wr_en_o    = wr_en;
   assign wr_addr_o  = wr_en ? cnt_q : addr_hold_q;
   assign wr_data_o  = wr_en ? data_q : data_hold_q;
   assign busy_o     = (state_q == S_COLLECT);
   assign done_o     = (state_q == S_DONE);
   assign overrun_o  = overrun_q;
   assign last_err_o = last_err_q;

endmodule

// File: tb/tb_conv_result_writer.sv
// tb_conv_result_writer: directed bench for conv_result_writer; expected
// writes go into a scoreboard that a negedge monitor drains.
module tb_conv_result_writer;

   localparam int N = 16;
   localparam int W = 8;
   localparam int A = 10;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start_i = 1'b0;
   logic [4:0]     size_i = '0;
   logic           relu_i = 1'b0;
   logic [N-1:0]   valid_i = '0;
   logic [N-1:0]   last_i = '0;
   logic [N*W-1:0] result_i = '0;
   logic           wr_en_o;
   logic [A-1:0]   wr_addr_o;
   logic [N*W-1:0] wr_data_o;
   logic           busy_o;
   logic           done_o;
   logic           overrun_o;
   logic           last_err_o;

   int n_pass = 0;
   int n_total = 0;

   logic [A-1:0]   exp_addr_q[$];
   logic [N*W-1:0] exp_data_q[$];
   logic [N*W-1:0] exp_w;

   conv_result_writer dut (
      .clk(clk),
      .rst(rst),
      .start_i(start_i),
      .ofmap_size_i(size_i),
      .relu_en_i(relu_i),
      .conv_valid_i(valid_i),
      .conv_last_i(last_i),
      .conv_result_i(result_i),
      .wr_en_o(wr_en_o),
      .wr_addr_o(wr_addr_o),
      .wr_data_o(wr_data_o),
      .busy_o(busy_o),
      .done_o(done_o),
      .overrun_o(overrun_o),
      .last_err_o(last_err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [N*W-1:0] act,
                      input logic [N*W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [A-1:0] a, input logic [N*W-1:0] d);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(d);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_wr_en"}, wr_en_o, 0);
      chk({tag, "_wr_addr"}, wr_addr_o, 0);
      chk({tag, "_wr_data"}, wr_data_o, 0);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_done"}, done_o, 0);
      chk({tag, "_overrun"}, overrun_o, 0);
      chk({tag, "_last_err"}, last_err_o, 0);
   endtask

   task automatic do_start(input logic [4:0] sz, input logic relu);
      start_i = 1'b1;
      size_i  = sz;
      relu_i  = relu;
      tick();
      start_i = 1'b0;
   endtask

   // Scoreboard monitor: every write strobe must match the oldest
   // expected write.
   always @(negedge clk) begin
      if (wr_en_o === 1'b1) begin
         if (exp_addr_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_write: got addr %0h expected none",
                     wr_addr_o);
         end else begin
            chk("wr_addr", wr_addr_o, exp_addr_q.pop_front());
            chk("wr_data", wr_data_o, exp_data_q.pop_front());
         end
      end
   end

   initial begin
      // Reset state
      tick();
      tick();
      chk_all_zero("reset");
      rst = 1'b0;

      // Aligned lanes, ReLU on: lane c = c-8, negatives clamp to 0
      for (int c = 0; c < N; c++) begin
         result_i[c*W +: W] = W'(c - 8);
         exp_w[c*W +: W] = (c < 8) ? 8'h00 : W'(c - 8);
      end
      for (int k = 0; k < 4; k++) push(A'(k), exp_w);
      do_start(5'd2, 1'b1);
      chk("t1_busy", busy_o, 1);
      for (int k = 0; k < 4; k++) begin
         valid_i = '1;
         last_i  = (k == 3) ? '1 : '0;
         tick();
      end
      valid_i = '0;
      last_i  = '0;
      chk("t1_final_wr", wr_en_o, 1);
      tick();
      chk("t1_done", done_o, 1);
      chk("t1_busy_low", busy_o, 0);
      chk("t1_overrun", overrun_o, 0);
      chk("t1_last_err", last_err_o, 0);
      tick();
      chk("t1_done_pulse", done_o, 0);

      // Skewed lanes, size 1, ReLU off: lane c = c*17
      for (int c = 0; c < N; c++) begin
         result_i[c*W +: W] = W'(c * 17);
         exp_w[c*W +: W] = W'(c * 17);
      end
      push(A'(0), exp_w);
      do_start(5'd1, 1'b0);
      chk("t2_busy_start", busy_o, 1);
      for (int c = 0; c < N; c++) begin
         valid_i = N'(1) << c;
         last_i  = N'(1) << c;
         tick();
         if (c < N - 1) chk("t2_no_early_wr", wr_en_o, 0);
         chk("t2_busy", busy_o, 1);
      end
      valid_i = '0;
      last_i  = '0;
      chk("t2_wr", wr_en_o, 1);
      tick();
      chk("t2_done", done_o, 1);
      chk("t2_last_err", last_err_o, 0);
      tick();

      // Overrun on lane 3: first value 0x11 kept, 0x22 dropped
      for (int c = 0; c < N; c++) begin
         result_i[c*W +: W] = W'(8'h40 + c);
         exp_w[c*W +: W] = W'(8'h40 + c);
      end
      result_i[3*W +: W] = 8'h11;
      exp_w[3*W +: W] = 8'h11;
      push(A'(0), exp_w);
      do_start(5'd1, 1'b0);
      valid_i = 16'h7fff;
      last_i  = '1;
      tick();
      chk("t3_no_overrun_yet", overrun_o, 0);
      result_i[3*W +: W] = 8'h22;
      valid_i = 16'h0008;
      tick();
      chk("t3_overrun", overrun_o, 1);
      valid_i = 16'h8000;
      tick();
      valid_i = '0;
      last_i  = '0;
      chk("t3_wr", wr_en_o, 1);
      tick();
      chk("t3_overrun_sticky", overrun_o, 1);
      chk("t3_last_err", last_err_o, 0);
      tick();

      // Zero size: done next cycle, no write, start clears overrun
      do_start(5'd0, 1'b0);
      chk("t5_zero_done", done_o, 1);
      chk("t5_zero_busy", busy_o, 0);
      chk("t5_overrun_clr", overrun_o, 0);
      tick();
      chk("t5_zero_done_pulse", done_o, 0);

      // Early last on word 0, size 2: all four words still written
      do_start(5'd2, 1'b0);
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < N; c++)
            result_i[c*W +: W] = {4'(k), 4'(c)};
         push(A'(k), result_i);
         valid_i = '1;
         last_i  = (k == 0) ? '1 : '0;
         tick();
         if (k == 0) chk("t4_err_before", last_err_o, 0);
         if (k == 1) chk("t4_err_after_w0", last_err_o, 1);
      end
      valid_i = '0;
      last_i  = '0;
      chk("t4_final_wr", wr_en_o, 1);
      tick();
      chk("t4_done", done_o, 1);
      chk("t4_last_err", last_err_o, 1);
      tick();

      // Start while busy: size 3 pulse mid-layer must be ignored
      do_start(5'd2, 1'b0);
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < N; c++)
            result_i[c*W +: W] = {4'(c), 4'(k + 5)};
         push(A'(k), result_i);
         valid_i = '1;
         last_i  = (k == 3) ? '1 : '0;
         start_i = (k == 1);
         size_i  = (k == 1) ? 5'd3 : 5'd2;
         tick();
      end
      start_i = 1'b0;
      valid_i = '0;
      last_i  = '0;
      chk("t5_final_wr", wr_en_o, 1);
      chk("t5_final_addr", wr_addr_o, 3);
      tick();
      chk("t5_done", done_o, 1);
      tick();

      // Reset mid-layer after two of four words
      do_start(5'd2, 1'b0);
      for (int k = 0; k < 2; k++) begin
         for (int c = 0; c < N; c++)
            result_i[c*W +: W] = {4'(k + 9), 4'(c)};
         push(A'(k), result_i);
         valid_i = '1;
         last_i  = (k == 0) ? '1 : '0;
         tick();
      end
      valid_i = '0;
      last_i  = '0;
      tick();
      chk("t6_err_pre_rst", last_err_o, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_all_zero("t6_rst");
      for (int c = 0; c < N; c++)
         result_i[c*W +: W] = W'(8'hA0 + c);
      push(A'(0), result_i);
      do_start(5'd1, 1'b0);
      valid_i = '1;
      last_i  = '1;
      tick();
      valid_i = '0;
      last_i  = '0;
      chk("t6_wr", wr_en_o, 1);
      chk("t6_addr", wr_addr_o, 0);
      tick();
      chk("t6_done", done_o, 1);
      tick();

      repeat (3) tick();
      chk("scoreboard_empty", exp_addr_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/conv_result_writer.md
# conv_result_writer

Collects the per-column final convolution results from the 16-lane accumulator array and writes them into the output-feature-map buffer. Each lane's output is `conv_valid`/`conv_last`/`conv_result`, and lanes arrive skewed in time. The block applies optional ReLU, packs one result per column into a 128-bit word, and issues one buffer write per complete column set. It sits between the accumulator array and the ofmap SRAM and reports completion to the layer controller.

## Interface
- N_COL, 16, number of accumulator lanes
- DATA_W, 8, result width per lane (signed two's complement)
- ADDR_W, 10, ofmap buffer word-address width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start_i  in  1  one-cycle pulse from the controller; begins a layer
- ofmap_size_i  in  5  ofmap side length; the layer produces ofmap_size_i² words; sampled on start_i
- relu_en_i  in  1  enable ReLU; sampled on start_i
- conv_valid_i  in  [N_COL]×1  per-lane result valid; no backpressure exists
- conv_last_i  in  [N_COL]×1  per-lane last-result marker
- conv_result_i  in  [N_COL]×DATA_W  per-lane result
- wr_en_o  out  1  buffer write strobe
- wr_addr_o  out  ADDR_W  word address, starting at 0
- wr_data_o  out  N_COL×DATA_W  packed word; lane c occupies bits [8c+7:8c]
- busy_o  out  1  high while in COLLECT
- done_o  out  1  one-cycle completion pulse
- overrun_o  out  1  sticky: a lane result was dropped
- last_err_o  out  1  sticky: conv_last inconsistent with word count

## Operation
- **States:**
  - IDLE → COLLECT on start_i.
  - If the latched size is 0, IDLE → DONE instead; no writes occur.
  - COLLECT → DONE after the write of word index size²−1.
  - DONE → IDLE unconditionally.
  - start_i outside IDLE is ignored.
- **Capture:** per lane, a data register, a last register and a `full` flag.
  - In COLLECT, when conv_valid_i[c]=1 and full[c]=0, store the result, store conv_last_i[c] and set full[c].
  - ReLU: if relu_en is latched high and the result MSB is 1, store 0.
- **Write cycle:** whenever all 16 `full` flags are set:
  - wr_en_o=1, wr_data_o = the captured registers, wr_addr_o = word counter.
  - At the end of the cycle, clear all flags and increment the counter.
- **Valid during a write cycle:** conv_valid_i[c] in a write cycle is captured into the freshly cleared slot. Set wins over clear.
- **Overrun:** conv_valid_i[c] while full[c]=1 and not in a write cycle sets overrun_o. The new value is dropped and the held value is kept.
- **Last check:** at each write, compute AND and OR over the captured last bits.
  - last_err_o is set if the OR is 1 but either the AND is 0 or the word is not index size²−1.
  - last_err_o is also set if the final word's AND is 0.
  - Termination is governed by the word count only.
- **Out-of-state inputs:** conv_valid_i outside COLLECT is ignored and flags nothing.
- **Arithmetic:** size² is computed as a 10-bit unsigned value (max 961) and compared against the ADDR_W-bit counter. The counter does not wrap within a legal layer.
- **Sticky flags:** overrun_o and last_err_o clear only on rst or on an accepted start_i.

## Timing
- **Reset values:** every output is 0. State is IDLE, all flags are clear, the counter is 0. A reset mid-COLLECT abandons the layer with no further writes.
- **Write latency:** wr_en_o is high in the cycle immediately after the clock edge that sets the last `full` flag.
- **Throughput:** with all lanes valid every cycle, one word is written per cycle after the first.
- **Write outputs:** wr_addr_o and wr_data_o are valid only while wr_en_o=1; otherwise they hold their last values.
- **Completion:** done_o pulses in the cycle after the final write cycle (DONE state). busy_o is low in that cycle.
- **Zero-size layer:** with size 0, done_o pulses the cycle after start_i.
- **Accepting a start:** busy_o rises the cycle after start_i is accepted.

## Test plan
- **Aligned lanes, ReLU on:** start with size=2, relu=1; four cycles of all lanes valid, lane c = c−8, conv_last set only on cycle 4.
  - Required: writes at addr 0,1,2,3; lanes 0–7 read 0x00, lanes 8–15 read 0..7.
  - Required: done_o pulses 1 cycle after the 4th write; no error flags.
- **Skewed lanes:** size=1; lane c valid at cycle t+c.
  - Required: exactly one write, at cycle t+16, addr 0, all lanes correct.
  - Required: busy_o is high from t−1 to the write cycle.
- **Overrun:** lane 3 valid twice before lane 15 arrives, values 0x11 then 0x22.
  - Required: overrun_o=1 and written lane 3 = 0x11; a subsequent accepted start clears overrun_o.
- **Early last:** size=2 with conv_last on all lanes at word 0.
  - Required: last_err_o=1; writes still continue to addr 3, then done_o.
- **Zero size, and start while busy:** start with size=0.
  - Required: no wr_en_o, done_o the next cycle.
  - Also: start_i pulsed mid-COLLECT has no effect on the counter or the latched size.
- **Reset mid-layer:** rst asserted after 2 of 4 words.
  - Required: all outputs 0 the next cycle; a new start with size=1 writes addr 0.
